mem_block_ctrl: RTL and testbench

Initiator-side controller for the 512-word x 32-bit block memory. It accepts single-block read/write requests from the processing datapath over a req/done handshake and drives the memory's address/we/oe/Din pins. It captures the 16-word (512-bit) Dout block, which the memory registers one cycle after oe. It rejects out-of-range block addresses and never issues them to the memory.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_block_ctrl.sv | 111 +++++++++++
 tb/tb_mem_block_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the block memory controller
package mem_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 9;
    localparam int DEPTH     = 512;
    localparam int BLOCK_W   = WORD_W * NUM_WORDS;
    localparam int MAX_BASE  = DEPTH - NUM_WORDS;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // A block fits only if its last word is still inside the memory.
    function automatic logic block_in_range(input logic [ADDR_W-1:0] base);
        return base <= ADDR_W'(MAX_BASE);
    endfunction

endpackage

// File: rtl/mem_block_ctrl.sv
// rtl/mem_block_ctrl.sv - single-block read/write initiator for the 512x32 block memory
module mem_block_ctrl
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BLOCK_W-1:0] rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic               mem_oe,
    output logic [BLOCK_W-1:0] mem_din,
    input  logic [BLOCK_W-1:0] mem_dout
);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [BLOCK_W-1:0] r_rdata;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic               r_mem_oe;
    logic [BLOCK_W-1:0] r_mem_din;

    // mem_addr and mem_din double as the request latches: they only move on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_oe   <= 1'b0;
            r_mem_din  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (req) begin
                        r_busy <= 1'b1;
                        if (!block_in_range(req_addr)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (req_we) begin
                            r_state    <= ST_WR_ISSUE;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= req_addr;
                            r_mem_din  <= req_wdata;
                        end else begin
                            r_state    <= ST_RD_ISSUE;
                            r_mem_oe   <= 1'b1;
                            r_mem_addr <= req_addr;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_DONE;
                    r_done   <= 1'b1;
                    r_err    <= 1'b0;
                end
                ST_RD_ISSUE: begin
                    // oe stays high so the registered Dout is not tri-stated while we wait.
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_rdata  <= mem_dout;
                    r_mem_oe <= 1'b0;
                    r_state  <= ST_DONE;
                    r_done   <= 1'b1;
                    r_err    <= 1'b0;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_err    <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_mem_oe <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_we   = r_mem_we;
    assign mem_oe   = r_mem_oe;
    assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// tb/tb_mem_block_ctrl.sv - directed table-driven bench for mem_block_ctrl with a memory model
module tb_mem_block_ctrl;
    import mem_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req = 1'b0;
    logic               req_we = 1'b0;
    logic [ADDR_W-1:0]  req_addr = '0;
    logic [BLOCK_W-1:0] req_wdata = '0;
    logic               busy, done, err;
    logic [BLOCK_W-1:0] rdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we, mem_oe;
    logic [BLOCK_W-1:0] mem_din;
    logic [BLOCK_W-1:0] mem_dout;

    always #5 clk = ~clk;

    mem_block_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Memory model: synchronous write, Dout registered one cycle after oe, floats when oe is low
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [BLOCK_W-1:0] dout_r = '0;
    logic [BLOCK_W-1:0] junk = '0;
    logic               mem_ready = 1'b0;
    logic               hyg = 1'b0;

    always @(posedge clk) begin
        junk <= {16{$urandom}};
        if (!mem_ready) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= 32'hA000_0000 | 32'(a);
            mem_ready <= 1'b1;
        end else begin
            if (mem_we)
                for (int i = 0; i < NUM_WORDS; i++)
                    mem[9'(mem_addr + 9'(i))] <= mem_din[i*WORD_W +: WORD_W];
            if (mem_oe)
                for (int i = 0; i < NUM_WORDS; i++)
                    dout_r[i*WORD_W +: WORD_W] <= mem[9'(mem_addr + 9'(i))];
        end
    end

    assign mem_dout = mem_oe ? dout_r : (hyg ? junk : 'z);

    int we_cyc = 0, oe_cyc = 0, overlap = 0, bad_addr = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) we_cyc <= we_cyc + 1;
        if (mem_oe) oe_cyc <= oe_cyc + 1;
        if (mem_we && mem_oe) overlap <= overlap + 1;
        if ((mem_we || mem_oe) && mem_addr > 9'(MAX_BASE)) bad_addr <= bad_addr + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Independent expectation of memory contents and of rdata
    logic [WORD_W-1:0]  shadow [DEPTH];
    logic [BLOCK_W-1:0] exp_rdata = '0;

    function automatic logic [BLOCK_W-1:0] make_block(input logic [31:0] seed);
        logic [BLOCK_W-1:0] b;
        for (int i = 0; i < NUM_WORDS; i++) b[i*WORD_W +: WORD_W] = seed + 32'(i);
        return b;
    endfunction

    function automatic logic [BLOCK_W-1:0] shadow_block(input logic [ADDR_W-1:0] base);
        logic [BLOCK_W-1:0] b;
        for (int i = 0; i < NUM_WORDS; i++) b[i*WORD_W +: WORD_W] = shadow[9'(base + 9'(i))];
        return b;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_wait: busy still %0d after %0d cycles, required 0", busy, n);
        end
    endtask

    // Latency = index of the negedge (1 = the cycle right after the accept edge) where done is seen.
    task automatic run_req(input string nm, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] seed, input logic exp_err, input int exp_lat);
        int lat = 0;
        int we0, oe0;
        logic err_seen = 1'b0;
        wait_idle();
        we0 = we_cyc;
        oe0 = oe_cyc;
        req = 1'b1;
        req_we = we;
        req_addr = addr;
        req_wdata = make_block(seed);
        @(posedge clk);
        #1 req = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                err_seen = err;
                break;
            end
        end
        if (!exp_err) begin
            if (we) for (int i = 0; i < NUM_WORDS; i++) shadow[9'(addr + 9'(i))] = seed + 32'(i);
            else exp_rdata = shadow_block(addr);
        end
        chk({nm, "_latency"}, BLOCK_W'(lat), BLOCK_W'(exp_lat));
        chk({nm, "_err"}, BLOCK_W'(err_seen), BLOCK_W'(exp_err));
        @(negedge clk);
        chk({nm, "_done_width"}, BLOCK_W'(done), '0);
        chk({nm, "_busy_after"}, BLOCK_W'(busy), '0);
        chk({nm, "_rdata"}, rdata, exp_rdata);
        chk({nm, "_we_cycles"}, BLOCK_W'(we_cyc - we0), BLOCK_W'((we && !exp_err) ? 1 : 0));
        chk({nm, "_oe_cycles"}, BLOCK_W'(oe_cyc - oe0), BLOCK_W'((!we && !exp_err) ? 2 : 0));
    endtask

    typedef struct {
        string            nm;
        logic             we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]      seed;
        logic             exp_err;
        int               exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int d0, oe0;
        vecs[0] = '{"wr32",      1'b1, 9'd32,  32'h0000_0000, 1'b0, 2};
        vecs[1] = '{"rd32",      1'b0, 9'd32,  32'h0,         1'b0, 3};
        vecs[2] = '{"wr496",     1'b1, 9'd496, 32'h5A5A_0000, 1'b0, 2};
        vecs[3] = '{"rd496",     1'b0, 9'd496, 32'h0,         1'b0, 3};
        vecs[4] = '{"rd497",     1'b0, 9'd497, 32'h0,         1'b1, 1};
        vecs[5] = '{"wr511",     1'b1, 9'd511, 32'hDEAD_0000, 1'b1, 1};
        vecs[6] = '{"wr16",      1'b1, 9'd16,  32'h1600_0000, 1'b0, 2};
        vecs[7] = '{"wr64",      1'b1, 9'd64,  32'hC0DE_0000, 1'b0, 2};
        vecs[8] = '{"rd64_b2b",  1'b0, 9'd64,  32'h0,         1'b0, 3};
        vecs[9] = '{"rd480",     1'b0, 9'd480, 32'h0,         1'b0, 3};

        for (int a = 0; a < DEPTH; a++) shadow[a] = 32'hA000_0000 | 32'(a);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", BLOCK_W'(busy), '0);
        chk("reset_done", BLOCK_W'(done), '0);
        chk("reset_err", BLOCK_W'(err), '0);
        chk("reset_strobes", BLOCK_W'({mem_we, mem_oe}), '0);
        chk("reset_addr", BLOCK_W'(mem_addr), '0);
        chk("reset_din", mem_din, '0);
        chk("reset_rdata", rdata, '0);

        for (int v = 0; v < 10; v++)
            run_req(vecs[v].nm, vecs[v].we, vecs[v].addr, vecs[v].seed, vecs[v].exp_err, vecs[v].exp_lat);

        // A second req during RD_ISSUE must be dropped, not queued
        wait_idle();
        d0 = done_cnt;
        oe0 = oe_cyc;
        req = 1'b1; req_we = 1'b0; req_addr = 9'd16;
        @(posedge clk);
        #1 req_addr = 9'd0;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (8) @(negedge clk);
        exp_rdata = shadow_block(9'd16);
        chk("busy_ignore_done_count", BLOCK_W'(done_cnt - d0), BLOCK_W'(1));
        chk("busy_ignore_oe_cycles", BLOCK_W'(oe_cyc - oe0), BLOCK_W'(2));
        chk("busy_ignore_rdata", rdata, exp_rdata);

        // Reset landing in RD_WAIT
        wait_idle();
        req = 1'b1; req_we = 1'b0; req_addr = 9'd32;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        chk("rst_mid_busy", BLOCK_W'(busy), '0);
        chk("rst_mid_done", BLOCK_W'(done), '0);
        chk("rst_mid_oe", BLOCK_W'(mem_oe), '0);
        chk("rst_mid_rdata", rdata, '0);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_done", BLOCK_W'(done_cnt - d0), '0);
        run_req("rd0_after_rst", 1'b0, 9'd0, 32'h0, 1'b0, 3);

        // Garbage on the floating Dout bus while idle must not reach rdata
        hyg = 1'b1;
        repeat (6) @(negedge clk);
        chk("hyg_rdata", rdata, exp_rdata);
        chk("hyg_no_x", BLOCK_W'($isunknown(rdata)), '0);
        hyg = 1'b0;

        chk("never_we_and_oe", BLOCK_W'(overlap), '0);
        chk("never_bad_addr_strobe", BLOCK_W'(bad_addr), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary, required completion");
        $fatal(1, "timeout");
    end

endmodule
